vga_display: RTL and testbench



---
 rtl/vga_display.sv | 163 ++++++++++++++++
 tb/tb_vga_display.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vga_display.sv
// VGA 640x480@60 timing generator with one movable square sprite, 3-3-2 RGB output.
// Define VGA_BORDER_EN to draw a one-pixel white frame around the active area.
module vga_display #(
    parameter int CLK_DIV   = 2,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int BALL_SIZE = 16,
    parameter int STEP      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] R_control,
    input  logic [2:0] G_control,
    input  logic [1:0] B_control,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [2:0] R,
    output logic [2:0] G,
    output logic [1:0] B,
    output logic       HS,
    output logic       VS
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] X_MAX    = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0] Y_MAX    = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] X_INIT   = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] Y_INIT   = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] STEP_V   = 10'(STEP);
    localparam logic [9:0] SIZE_V   = 10'(BALL_SIZE);

    logic [DIV_W-1:0] div_cnt_r;
    logic [9:0]       hcnt_r;
    logic [9:0]       vcnt_r;
    logic [9:0]       ball_x_r;
    logic [9:0]       ball_y_r;
    logic             pix_en_s;
    logic             tick_s;
    logic             active_s;
    logic             in_ball_s;
    logic             hs_s;
    logic             vs_s;
    logic [7:0]       rgb_s;
    logic [9:0]       ball_x_nxt_s;
    logic [9:0]       ball_y_nxt_s;

    // Distances are compared before any subtraction so the position never underflows.
    function automatic logic [9:0] move_axis(input logic [9:0] pos, input logic dec,
                                             input logic inc, input logic [9:0] lim);
        logic [9:0] res;
        res = pos;
        if (dec && !inc) begin
            if (pos >= STEP_V) res = pos - STEP_V;
            else               res = 10'd0;
        end else if (inc && !dec) begin
            if ((lim - pos) >= STEP_V) res = pos + STEP_V;
            else                       res = lim;
        end else begin
            res = pos;
        end
        return res;
    endfunction

    assign pix_en_s = (div_cnt_r == DIV_LAST);
    assign tick_s   = pix_en_s && (hcnt_r == H_LAST) && (vcnt_r == V_LAST);

    // Pixel-enable divider and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= '0;
            hcnt_r    <= 10'd0;
            vcnt_r    <= 10'd0;
        end else if (pix_en_s) begin
            div_cnt_r <= '0;
            if (hcnt_r == H_LAST) begin
                hcnt_r <= 10'd0;
                vcnt_r <= (vcnt_r == V_LAST) ? 10'd0 : vcnt_r + 10'd1;
            end else begin
                hcnt_r <= hcnt_r + 10'd1;
            end
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Sync decode and pixel colour for the current counter values.
    always_comb begin
        hs_s      = !((hcnt_r >= HS_FIRST) && (hcnt_r <= HS_LAST));
        vs_s      = !((vcnt_r >= VS_FIRST) && (vcnt_r <= VS_LAST));
        active_s  = (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
        in_ball_s = (hcnt_r >= ball_x_r) && ((hcnt_r - ball_x_r) < SIZE_V) &&
                    (vcnt_r >= ball_y_r) && ((vcnt_r - ball_y_r) < SIZE_V);
        rgb_s     = 8'd0;
        if (active_s && in_ball_s) begin
            rgb_s = {R_control, G_control, B_control};
`ifdef VGA_BORDER_EN
        end else if (active_s && ((hcnt_r == 10'd0) || (hcnt_r == H_ACT - 10'd1) ||
                                  (vcnt_r == 10'd0) || (vcnt_r == V_ACT - 10'd1))) begin
            rgb_s = 8'hFF;
`endif
        end else begin
            rgb_s = 8'd0;
        end
    end

    // Candidate sprite position for the next frame.
    always_comb begin
        ball_x_nxt_s = move_axis(ball_x_r, left, right, X_MAX);
        ball_y_nxt_s = move_axis(ball_y_r, up, down, Y_MAX);
    end

    // Sprite position changes only at the frame tick, so a frame is never torn.
    always_ff @(posedge clk) begin
        if (rst) begin
            ball_x_r <= X_INIT;
            ball_y_r <= Y_INIT;
        end else if (tick_s) begin
            ball_x_r <= ball_x_nxt_s;
            ball_y_r <= ball_y_nxt_s;
        end else begin
            ball_x_r <= ball_x_r;
            ball_y_r <= ball_y_r;
        end
    end

    // Registered video outputs, all one clock behind the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            HS <= 1'b1;
            VS <= 1'b1;
            R  <= 3'd0;
            G  <= 3'd0;
            B  <= 2'd0;
        end else begin
            HS <= hs_s;
            VS <= vs_s;
            R  <= rgb_s[7:5];
            G  <= rgb_s[4:2];
            B  <= rgb_s[1:0];
        end
    end

endmodule

// File: tb/tb_vga_display.sv
// Self-checking bench for vga_display: a reduced-timing instance for whole-frame sprite tests
// and a default-timing instance checked over its first lines.
module tb_vga_display;

    localparam int DIV  = 2;
    localparam int S_HA = 32, S_HFP = 4, S_HSW = 6, S_HBP = 6;
    localparam int S_VA = 24, S_VFP = 2, S_VSW = 2, S_VBP = 2;
    localparam int S_BS = 4,  S_STEP = 4;
    localparam int S_HT = S_HA + S_HFP + S_HSW + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VSW + S_VBP;
    localparam int S_FR = S_HT * S_VT * DIV;
    localparam int F_FRPIX = 800 * 525;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] R_control = 3'd0;
    logic [2:0] G_control = 3'd0;
    logic [1:0] B_control = 2'd0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;

    logic [2:0] r_s, g_s, r_f, g_f;
    logic [1:0] b_s, b_f;
    logic       hs_s, vs_s, hs_f, vs_f;
    logic [9:0] obs_s, obs_f;

    int k, checks, errors;
    int sbx, sby, fbx, fby;

    always #5 clk = ~clk;

    vga_display #(
        .CLK_DIV(DIV), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
        .BALL_SIZE(S_BS), .STEP(S_STEP)
    ) dut (
        .clk(clk), .rst(rst), .R_control(R_control), .G_control(G_control),
        .B_control(B_control), .up(up), .down(down), .left(left), .right(right),
        .R(r_s), .G(g_s), .B(b_s), .HS(hs_s), .VS(vs_s)
    );

    vga_display dut_full (
        .clk(clk), .rst(rst), .R_control(R_control), .G_control(G_control),
        .B_control(B_control), .up(up), .down(down), .left(left), .right(right),
        .R(r_f), .G(g_f), .B(b_f), .HS(hs_f), .VS(vs_f)
    );

    assign obs_s = {hs_s, vs_s, r_s, g_s, b_s};
    assign obs_f = {hs_f, vs_f, r_f, g_f, b_f};

    // Expected {HS,VS,RGB} for pixel number p since reset, from the raster arithmetic.
    function automatic logic [9:0] model_px(input int p, input int ha, input int hfp,
            input int hsw, input int hbp, input int va, input int vfp, input int vsw,
            input int vbp, input int bx, input int by, input int bs, input logic [7:0] col);
        int ht, vt, h, v;
        logic hs, vs;
        logic [7:0] rgb;
        ht  = ha + hfp + hsw + hbp;
        vt  = va + vfp + vsw + vbp;
        h   = p % ht;
        v   = (p / ht) % vt;
        hs  = !(h >= ha + hfp && h < ha + hfp + hsw);
        vs  = !(v >= va + vfp && v < va + vfp + vsw);
        rgb = 8'd0;
        if (h < ha && v < va) begin
            if (h >= bx && h < bx + bs && v >= by && v < by + bs) rgb = col;
`ifdef VGA_BORDER_EN
            else if (h == 0 || h == ha - 1 || v == 0 || v == va - 1) rgb = 8'hFF;
`endif
        end
        return {hs, vs, rgb};
    endfunction

    function automatic int move(input int pos, input logic dec, input logic inc,
                                input int step, input int maxv);
        if (dec && !inc) return (pos - step < 0) ? 0 : pos - step;
        if (inc && !dec) return (pos + step > maxv) ? maxv : pos + step;
        return pos;
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d after reset)", tag, obs, exp, k);
        end
    endtask

    // One clock: predict outputs, advance the model, then compare after the edge.
    task automatic cyc();
        logic [9:0] es, ef;
        logic [7:0] col;
        int p;
        p   = k / DIV;
        col = {R_control, G_control, B_control};
        if (rst) begin
            es = 10'h300;
            ef = 10'h300;
            k = 0; sbx = (S_HA - S_BS) / 2; sby = (S_VA - S_BS) / 2; fbx = 312; fby = 232;
        end else begin
            es = model_px(p, S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP,
                          sbx, sby, S_BS, col);
            ef = model_px(p, 640, 16, 96, 48, 480, 10, 2, 33, fbx, fby, 16, col);
            if (k % DIV == DIV - 1 && p % (S_HT * S_VT) == S_HT * S_VT - 1) begin
                sbx = move(sbx, left, right, S_STEP, S_HA - S_BS);
                sby = move(sby, up, down, S_STEP, S_VA - S_BS);
            end
            if (k % DIV == DIV - 1 && p % F_FRPIX == F_FRPIX - 1) begin
                fbx = move(fbx, left, right, 4, 624);
                fby = move(fby, up, down, 4, 464);
            end
            k++;
        end
        @(posedge clk);
        #1;
        check("scaled", obs_s, es);
        check("full", obs_f, ef);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        k = 0;
        @(negedge clk);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        R_control = 3'd5; G_control = 3'd2; B_control = 2'd1;
        run(S_FR + 10);
        down = 1'b1;                 run(3 * S_FR); down = 1'b0;
        left = 1'b1; right = 1'b1;   run(S_FR);     left = 1'b0; right = 1'b0;
        up = 1'b1; down = 1'b1;      run(S_FR);     down = 1'b0;
        run(6 * S_FR);               up = 1'b0;
        right = 1'b1;                run(5 * S_FR); right = 1'b0;
        left = 1'b1; down = 1'b1;    run(2 * S_FR); left = 1'b0; down = 1'b0;
        for (int i = 0; i < 2 * S_FR; i++) begin
            if (i % 2 == 0) down = ~down;
            cyc();
        end
        down = 1'b0;
        for (int f = 0; f < 4; f++) begin
            R_control = 3'($urandom); G_control = 3'($urandom); B_control = 2'($urandom);
            for (int i = 0; i < S_FR; i++) begin
                if ($urandom_range(0, 15) == 0) {up, down, left, right} = 4'($urandom);
                cyc();
            end
        end
        run($urandom_range(100, 1000));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        {up, down, left, right} = 4'b0000;
        run(S_FR + 20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
